// File: rtl/rob_if.sv
// Issue, result-broadcast, operand-query and commit signals between the reorder buffer and the core.
interface rob_if #(
  parameter int ENTRY_W = 5
);
  logic               issue_valid;
  logic [5:0]         issue_rd;
  logic               issue_chk_pc;
  logic [31:0]        issue_pred_pc;
  logic               issue_is_store;
  logic               rob_full;
  logic [ENTRY_W-1:0] issue_entry;

  logic               rs_broadcast;
  logic [ENTRY_W-1:0] rs_entry_out;
  logic [31:0]        rs_result;
  logic [31:0]        rs_pc_out;
  logic               lsb_broadcast;
  logic [ENTRY_W-1:0] lsb_entry;
  logic [31:0]        lsb_result;

  logic [ENTRY_W-1:0] query_j_entry;
  logic [ENTRY_W-1:0] query_k_entry;
  logic               query_j_ready;
  logic               query_k_ready;
  logic [31:0]        query_j_value;
  logic [31:0]        query_k_value;

  logic               rob_commit;
  logic [ENTRY_W-1:0] rob_entry;
  logic [31:0]        rob_result;
  logic [5:0]         commit_rd;
  logic               store_commit;
  logic               rollback;
  logic [31:0]        rollback_pc;

  modport master (
    output issue_valid, issue_rd, issue_chk_pc, issue_pred_pc, issue_is_store,
    input  rob_full, issue_entry,
    output rs_broadcast, rs_entry_out, rs_result, rs_pc_out,
    output lsb_broadcast, lsb_entry, lsb_result,
    output query_j_entry, query_k_entry,
    input  query_j_ready, query_k_ready, query_j_value, query_k_value,
    input  rob_commit, rob_entry, rob_result, commit_rd, store_commit, rollback, rollback_pc
  );

  modport slave (
    input  issue_valid, issue_rd, issue_chk_pc, issue_pred_pc, issue_is_store,
    output rob_full, issue_entry,
    input  rs_broadcast, rs_entry_out, rs_result, rs_pc_out,
    input  lsb_broadcast, lsb_entry, lsb_result,
    input  query_j_entry, query_k_entry,
    output query_j_ready, query_k_ready, query_j_value, query_k_value,
    output rob_commit, rob_entry, rob_result, commit_rd, store_commit, rollback, rollback_pc
  );
endinterface

// File: rtl/rob.sv
// Reorder buffer: hands out tags at issue, captures RS/LSB results, retires in program order
// and raises a one-cycle rollback when a checked next-PC turns out to be mispredicted.
module rob #(
  parameter int ROB_SIZE   = 16,
  parameter int ENTRY_W    = 5,
  parameter int ENTRY_NULL = ROB_SIZE
) (
  input logic  clk,
  input logic  rst,
  input logic  rdy,
  rob_if.slave bus
);
  localparam int PTR_W = $clog2(ROB_SIZE);
  localparam int CNT_W = $clog2(ROB_SIZE + 1);
  localparam logic [ENTRY_W-1:0] NULL_TAG = ENTRY_W'(ENTRY_NULL);

  typedef enum logic [1:0] {EMPTY, WAITING, READY} entry_state_e;

  entry_state_e state_q [ROB_SIZE];
  entry_state_e state_d [ROB_SIZE];

  logic [5:0]  rd_q        [ROB_SIZE];
  logic        chk_pc_q    [ROB_SIZE];
  logic        is_store_q  [ROB_SIZE];
  logic [31:0] pred_pc_q   [ROB_SIZE];
  logic [31:0] value_q     [ROB_SIZE];
  logic [31:0] actual_pc_q [ROB_SIZE];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic                issue_ok, retire, commit_now, mispredict, flush;
  logic [ROB_SIZE-1:0] rs_hit, lsb_hit;

  assign bus.rob_full    = (count_q == CNT_W'(ROB_SIZE));
  assign bus.issue_entry = ENTRY_W'(tail_q);

  // The cycle after a rollback pulse wipes the buffer; nothing else may act during it.
  assign flush      = bus.rollback;
  assign issue_ok   = bus.issue_valid && !bus.rob_full;
  assign retire     = (state_q[head_q] == READY);
  assign commit_now = retire && !flush;
  assign mispredict = chk_pc_q[head_q] && (actual_pc_q[head_q] != pred_pc_q[head_q]);

  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      rs_hit[i]  = bus.rs_broadcast && (bus.rs_entry_out == ENTRY_W'(i)) && (state_q[i] == WAITING);
      lsb_hit[i] = bus.lsb_broadcast && (bus.lsb_entry == ENTRY_W'(i)) && (state_q[i] == WAITING)
                   && !rs_hit[i];
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < ROB_SIZE; i++) state_d[i] = state_q[i];

    if (flush) begin
      for (int i = 0; i < ROB_SIZE; i++) state_d[i] = EMPTY;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (rs_hit[i] || lsb_hit[i]) state_d[i] = READY;
      end
      if (retire) begin
        state_d[head_q] = EMPTY;
        head_d          = head_q + PTR_W'(1);
      end
      // A full buffer never retires into the tail slot, so head and tail cannot collide here.
      if (issue_ok) begin
        state_d[tail_q] = WAITING;
        tail_d          = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(issue_ok) - CNT_W'(retire);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) state_q[i] <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: payload arrays are not reset; an entry's state gates every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      if (issue_ok) begin
        rd_q[tail_q]       <= bus.issue_rd;
        chk_pc_q[tail_q]   <= bus.issue_chk_pc;
        pred_pc_q[tail_q]  <= bus.issue_pred_pc;
        is_store_q[tail_q] <= bus.issue_is_store;
      end
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (rs_hit[i]) begin
          value_q[i]     <= bus.rs_result;
          actual_pc_q[i] <= bus.rs_pc_out;
        end else if (lsb_hit[i]) begin
          value_q[i] <= bus.lsb_result;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rob_commit   <= 1'b0;
      bus.store_commit <= 1'b0;
      bus.rollback     <= 1'b0;
      bus.rob_entry    <= NULL_TAG;
      bus.rob_result   <= '0;
      bus.commit_rd    <= '0;
      bus.rollback_pc  <= '0;
    end else if (rdy) begin
      bus.rob_commit   <= commit_now;
      bus.store_commit <= commit_now && is_store_q[head_q];
      bus.rollback     <= commit_now && mispredict;
      if (commit_now) begin
        bus.rob_entry  <= ENTRY_W'(head_q);
        bus.rob_result <= value_q[head_q];
        bus.commit_rd  <= rd_q[head_q];
        if (mispredict) bus.rollback_pc <= actual_pc_q[head_q];
      end
    end
  end

  // Operand lookup: the null tag is always ready; a same-cycle broadcast bypasses the buffer.
  logic [ENTRY_W-1:0] q_tag   [2];
  logic               q_ready [2];
  logic [31:0]        q_value [2];

  assign q_tag[0] = bus.query_j_entry;
  assign q_tag[1] = bus.query_k_entry;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_ready[p] = 1'b0;
      q_value[p] = '0;
      if (q_tag[p] == NULL_TAG) begin
        q_ready[p] = 1'b1;
      end else if (bus.rs_broadcast && (bus.rs_entry_out == q_tag[p])) begin
        q_ready[p] = 1'b1;
        q_value[p] = bus.rs_result;
      end else if (bus.lsb_broadcast && (bus.lsb_entry == q_tag[p])) begin
        q_ready[p] = 1'b1;
        q_value[p] = bus.lsb_result;
      end else if ((q_tag[p] < ENTRY_W'(ROB_SIZE)) && (state_q[q_tag[p][PTR_W-1:0]] == READY)) begin
        q_ready[p] = 1'b1;
        q_value[p] = value_q[q_tag[p][PTR_W-1:0]];
      end
    end
  end

  assign bus.query_j_ready = q_ready[0];
  assign bus.query_j_value = q_value[0];
  assign bus.query_k_ready = q_ready[1];
  assign bus.query_k_value = q_value[1];
endmodule
